inv_mix_columns: RTL and testbench

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

---
 rtl/inv_mix_columns.sv | 127 ++++++++++++
 tb/tb_inv_mix_columns.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns engine: captures one 128-bit state, transforms one column
// per clock over four cycles, then holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a new state, nothing to present
// BUSY  | transforming column r_col of the working register
// DONE  | result valid on OutState, waiting for OutReady
module inv_mix_columns (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] InState,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] OutState
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  // Multiples of 2, 4 and 8 are shared by all four inverse coefficients.
  function automatic logic [31:0] inv_col(input logic [31:0] s);
    logic [7:0] b [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      b[i]   = s[31 - 8*i -: 8];
      x2[i]  = xtime(b[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m09[i] = x8[i] ^ b[i];
      m0b[i] = x8[i] ^ x2[i] ^ b[i];
      m0d[i] = x8[i] ^ x4[i] ^ b[i];
      m0e[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    r[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
    r[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
    r[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
    r[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
    return r;
  endfunction

  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
      default: w_col_in = r_work[127:96];
    endcase
  end

  assign w_col_out = inv_col(w_col_in);

  always_comb begin
    w_state_nxt = r_state;
    InReady     = 1'b0;
    OutValid    = 1'b0;
    case (r_state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_col == 2'd3) w_state_nxt = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_work <= 128'h0;
      r_col  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid) begin
            r_work <= InState;
            r_col  <= 2'd0;
          end
        end
        BUSY: begin
          case (r_col)
            2'd0: r_work[127:96] <= w_col_out;
            2'd1: r_work[95:64]  <= w_col_out;
            2'd2: r_work[63:32]  <= w_col_out;
            2'd3: r_work[31:0]   <= w_col_out;
            default: r_work[127:96] <= w_col_out;
          endcase
          r_col <= r_col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign OutState = r_work;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Bench for inv_mix_columns: directed AES vectors, backpressure, reset abort and
// random states compared against a generic GF(2^8) matrix model.
module tb_inv_mix_columns;

  logic         Clk;
  logic         Rst_n;
  logic         InValid;
  logic         InReady;
  logic [127:0] InState;
  logic         OutValid;
  logic         OutReady;
  logic [127:0] OutState;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] C6_VEC   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  logic [7:0] IMC_M [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                               '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                               '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                               '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
  logic [7:0] MC_M [4][4]  = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                               '{8'h01, 8'h02, 8'h03, 8'h01},
                               '{8'h01, 8'h01, 8'h02, 8'h03},
                               '{8'h03, 8'h01, 8'h01, 8'h02}};

  inv_mix_columns dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .InState  (InState),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutState (OutState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Shift-and-add GF(2^8) multiply, independent of any fixed coefficient set.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] st, input logic [7:0] m [4][4]);
    logic [127:0] o;
    logic [7:0]   acc;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[r][k], st[127 - 32*c - 8*k -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE back to IDLE; s_busy is driven on InState
  // (with InValid=hold) while the block is busy, to prove it is ignored.
  task automatic do_txn(input logic [127:0] s, input logic [127:0] exp, input int stall,
                        input bit hold, input logic [127:0] s_busy, input bit rnd_rdy);
    int lat;
    chk("in_ready_idle", 128'(InReady), 128'(1));
    InValid = 1'b1;
    InState = s;
    @(posedge Clk); #1;
    InValid = hold;
    InState = s_busy;
    chk("in_ready_busy", 128'(InReady), 128'(0));
    lat = 0;
    while (!OutValid && lat < 12) begin
      OutReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge Clk); #1;
      lat++;
    end
    OutReady = 1'b0;
    chk("latency", 128'(lat), 128'(4));
    chk("result", OutState, exp);
    chk("mc_roundtrip", mat_apply(OutState, MC_M), s);
    repeat (stall) begin
      @(posedge Clk); #1;
    end
    if (stall > 0) begin
      chk("stall_valid", 128'(OutValid), 128'(1));
      chk("stall_state", OutState, exp);
      chk("stall_in_ready", 128'(InReady), 128'(0));
    end
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    InValid  = 1'b0;
    chk("ret_in_ready", 128'(InReady), 128'(1));
    chk("ret_out_valid", 128'(OutValid), 128'(0));
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] s2;
    Rst_n    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    InState  = 128'h0;
    #12;
    chk("rst_in_ready", 128'(InReady), 128'(1));
    chk("rst_out_valid", 128'(OutValid), 128'(0));
    chk("rst_out_state", OutState, 128'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("release_no_capture", 128'(InReady), 128'(1));

    do_txn(FIPS_IN, FIPS_OUT, 0, 1'b0, rand128(), 1'b0);
    do_txn(C6_VEC, C6_VEC, 0, 1'b0, rand128(), 1'b0);
    do_txn(128'h0, 128'h0, 0, 1'b0, rand128(), 1'b0);
    do_txn(FIPS_IN, FIPS_OUT, 10, 1'b0, rand128(), 1'b0);

    // New data with InValid held high while busy; accepted only afterwards.
    s2 = rand128();
    do_txn(FIPS_IN, FIPS_OUT, 2, 1'b1, s2, 1'b0);
    do_txn(s2, mat_apply(s2, IMC_M), 0, 1'b0, rand128(), 1'b0);

    // Reset after column 1 has been written back.
    InValid = 1'b1;
    InState = C6_VEC ^ 128'h1234;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(OutValid), 128'(0));
    chk("abort_out_state", OutState, 128'h0);
    chk("abort_in_ready", 128'(InReady), 128'(1));
    #2;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("abort_release_idle", 128'(InReady), 128'(1));
    chk("abort_release_nv", 128'(OutValid), 128'(0));
    do_txn(FIPS_IN, FIPS_OUT, 0, 1'b0, rand128(), 1'b0);

    for (int n = 0; n < 1000; n++) begin
      s = rand128();
      do_txn(s, mat_apply(s, IMC_M), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             rand128(), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
